udp_axil_regs: RTL and testbench

AXI4-Lite responder (slave) register file for the UDP/Ethernet datapath. It terminates the 32-bit AXI-Lite M00 port of the PS7 peripheral interconnect and exposes decoded configuration (MAC, IP, ports, enables) to the packet engine. It also returns status and event counters to software.
- One outstanding write and one outstanding read at a time.
- Write and read channels are independent of each other.

---
 rtl/udp_regs_pkg.sv | 45 ++++
 rtl/udp_regs_evt_cnt.sv | 20 ++
 rtl/udp_axil_regs.sv | 208 ++++++++++++++++++++
 tb/tb_udp_axil_regs.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_regs_pkg.sv
// Shared definitions for the UDP/Ethernet AXI-Lite register file:
// register offsets, response codes, CTRL bit positions and the cfg bundle.
package udp_regs_pkg;

    localparam logic [7:0] OFF_CTRL     = 8'h00;
    localparam logic [7:0] OFF_MAC_LO   = 8'h04;
    localparam logic [7:0] OFF_MAC_HI   = 8'h08;
    localparam logic [7:0] OFF_SRC_IP   = 8'h0C;
    localparam logic [7:0] OFF_DST_IP   = 8'h10;
    localparam logic [7:0] OFF_PORTS    = 8'h14;
    localparam logic [7:0] OFF_STATUS   = 8'h18;
    localparam logic [7:0] OFF_TX_CNT   = 8'h1C;
    localparam logic [7:0] OFF_RX_CNT   = 8'h20;
    localparam logic [7:0] OFF_IRQ_STAT = 8'h24;
    localparam logic [7:0] OFF_IRQ_MASK = 8'h28;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int unsigned CTRL_TX_EN    = 0;
    localparam int unsigned CTRL_RX_EN    = 1;
    localparam int unsigned CTRL_SOFT_RST = 2;

    typedef struct packed {
        logic [47:0] mac;
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic        tx_en;
        logic        rx_en;
    } cfg_t;

    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int unsigned i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/udp_regs_evt_cnt.sv
// 32-bit wrapping event counter; synchronous clear takes priority over increment.
module udp_regs_evt_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        inc,
    output logic [31:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/udp_axil_regs.sv
// AXI4-Lite register file for the UDP engine: configuration, status and event counters.
// Optional interrupt registers are built when UDP_REGS_IRQ_EN is defined.
module udp_axil_regs #(
    parameter int unsigned ADDR_W       = 8,
    parameter logic [47:0] DEF_MAC      = 48'h0200_0000_0001,
    parameter logic [31:0] DEF_SRC_IP   = 32'hC0A8_010A,
    parameter logic [31:0] DEF_DST_IP   = 32'hC0A8_0164,
    parameter logic [15:0] DEF_SRC_PORT = 16'd5000,
    parameter logic [15:0] DEF_DST_PORT = 16'd5001
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic [ADDR_W-1:0] S_AXI_awaddr,
    input  logic              S_AXI_awvalid,
    output logic              S_AXI_awready,
    input  logic [31:0]       S_AXI_wdata,
    input  logic [3:0]        S_AXI_wstrb,
    input  logic              S_AXI_wvalid,
    output logic              S_AXI_wready,
    output logic [1:0]        S_AXI_bresp,
    output logic              S_AXI_bvalid,
    input  logic              S_AXI_bready,
    input  logic [ADDR_W-1:0] S_AXI_araddr,
    input  logic              S_AXI_arvalid,
    output logic              S_AXI_arready,
    output logic [31:0]       S_AXI_rdata,
    output logic [1:0]        S_AXI_rresp,
    output logic              S_AXI_rvalid,
    input  logic              S_AXI_rready,
    output logic [47:0]       cfg_mac,
    output logic [31:0]       cfg_src_ip,
    output logic [31:0]       cfg_dst_ip,
    output logic [15:0]       cfg_src_port,
    output logic [15:0]       cfg_dst_port,
    output logic              cfg_tx_en,
    output logic              cfg_rx_en,
    output logic              cfg_soft_rst,
    input  logic              sts_link_up,
    input  logic              sts_tx_busy,
    input  logic              evt_tx_done,
    input  logic              evt_rx_pkt,
    output logic              irq
);

    import udp_regs_pkg::*;

    cfg_t              cfg;
    logic              aw_hs, w_hs, b_hs, ar_hs, do_write;
    logic [ADDR_W-1:0] aw_addr_q, wr_addr, wr_word, rd_word;
    logic [31:0]       wdata_q, wr_data, mac_hi_new, rd_data;
    logic [3:0]        wstrb_q, wr_strb;
    logic              wr_err, rd_err;
    logic [31:0]       tx_cnt, rx_cnt;

    assign aw_hs = S_AXI_awvalid & S_AXI_awready;
    assign w_hs  = S_AXI_wvalid & S_AXI_wready;
    assign b_hs  = S_AXI_bvalid & S_AXI_bready;
    assign ar_hs = S_AXI_arvalid & S_AXI_arready;
    assign S_AXI_arready = ~S_AXI_rvalid;

    // A channel is "held" once its ready has dropped; the live bus is used in the handshake cycle
    // so the write commits on the edge that completes the second handshake.
    assign wr_addr  = S_AXI_awready ? S_AXI_awaddr : aw_addr_q;
    assign wr_data  = S_AXI_wready  ? S_AXI_wdata  : wdata_q;
    assign wr_strb  = S_AXI_wready  ? S_AXI_wstrb  : wstrb_q;
    assign do_write = (aw_hs | ~S_AXI_awready) & (w_hs | ~S_AXI_wready) & ~S_AXI_bvalid;
    assign wr_word  = {wr_addr[ADDR_W-1:2], 2'b00};
    assign rd_word  = {S_AXI_araddr[ADDR_W-1:2], 2'b00};
    assign mac_hi_new = apply_strb({16'h0000, cfg.mac[47:32]}, wr_data, {2'b00, wr_strb[1:0]});

    always_comb begin
        wr_err = 1'b0;
        case (wr_word)
            ADDR_W'(OFF_CTRL), ADDR_W'(OFF_MAC_LO), ADDR_W'(OFF_MAC_HI),
            ADDR_W'(OFF_SRC_IP), ADDR_W'(OFF_DST_IP), ADDR_W'(OFF_PORTS),
            ADDR_W'(OFF_STATUS), ADDR_W'(OFF_TX_CNT), ADDR_W'(OFF_RX_CNT): wr_err = 1'b0;
`ifdef UDP_REGS_IRQ_EN
            ADDR_W'(OFF_IRQ_STAT), ADDR_W'(OFF_IRQ_MASK): wr_err = 1'b0;
`endif
            default: wr_err = 1'b1;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            S_AXI_awready <= 1'b1;
            S_AXI_wready  <= 1'b1;
            S_AXI_bvalid  <= 1'b0;
            S_AXI_bresp   <= RESP_OKAY;
            aw_addr_q     <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
        end else begin
            if (aw_hs) begin
                S_AXI_awready <= 1'b0;
                aw_addr_q     <= S_AXI_awaddr;
            end
            if (w_hs) begin
                S_AXI_wready <= 1'b0;
                wdata_q      <= S_AXI_wdata;
                wstrb_q      <= S_AXI_wstrb;
            end
            if (do_write) begin
                S_AXI_bvalid <= 1'b1;
                S_AXI_bresp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
            end else if (b_hs) begin
                S_AXI_bvalid  <= 1'b0;
                S_AXI_awready <= 1'b1;
                S_AXI_wready  <= 1'b1;
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            cfg <= '{mac: DEF_MAC, src_ip: DEF_SRC_IP, dst_ip: DEF_DST_IP,
                     src_port: DEF_SRC_PORT, dst_port: DEF_DST_PORT,
                     tx_en: 1'b0, rx_en: 1'b0};
            cfg_soft_rst <= 1'b0;
        end else begin
            cfg_soft_rst <= do_write && (wr_word == ADDR_W'(OFF_CTRL)) &&
                            wr_strb[0] && wr_data[CTRL_SOFT_RST];
            if (do_write) begin
                case (wr_word)
                    ADDR_W'(OFF_CTRL): if (wr_strb[0]) begin
                        cfg.tx_en <= wr_data[CTRL_TX_EN];
                        cfg.rx_en <= wr_data[CTRL_RX_EN];
                    end
                    ADDR_W'(OFF_MAC_LO): cfg.mac[31:0]  <= apply_strb(cfg.mac[31:0], wr_data, wr_strb);
                    ADDR_W'(OFF_MAC_HI): cfg.mac[47:32] <= mac_hi_new[15:0];
                    ADDR_W'(OFF_SRC_IP): cfg.src_ip     <= apply_strb(cfg.src_ip, wr_data, wr_strb);
                    ADDR_W'(OFF_DST_IP): cfg.dst_ip     <= apply_strb(cfg.dst_ip, wr_data, wr_strb);
                    ADDR_W'(OFF_PORTS):  {cfg.src_port, cfg.dst_port} <=
                        apply_strb({cfg.src_port, cfg.dst_port}, wr_data, wr_strb);
                    default: ;
                endcase
            end
        end
    end

    assign cfg_mac      = cfg.mac;
    assign cfg_src_ip   = cfg.src_ip;
    assign cfg_dst_ip   = cfg.dst_ip;
    assign cfg_src_port = cfg.src_port;
    assign cfg_dst_port = cfg.dst_port;
    assign cfg_tx_en    = cfg.tx_en;
    assign cfg_rx_en    = cfg.rx_en;

    udp_regs_evt_cnt u_tx_cnt (.clk(ACLK), .rst(ARESET), .clr(cfg_soft_rst), .inc(evt_tx_done), .count(tx_cnt));
    udp_regs_evt_cnt u_rx_cnt (.clk(ACLK), .rst(ARESET), .clr(cfg_soft_rst), .inc(evt_rx_pkt),  .count(rx_cnt));

`ifdef UDP_REGS_IRQ_EN
    logic [1:0] irq_stat, irq_mask, irq_w1c;

    assign irq_w1c = (do_write && (wr_word == ADDR_W'(OFF_IRQ_STAT)) && wr_strb[0]) ? wr_data[1:0] : 2'b00;

    // Clear is applied before the OR so a same-cycle event survives the W1C.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            irq_stat <= '0;
            irq_mask <= '0;
            irq      <= 1'b0;
        end else begin
            irq_stat <= (irq_stat & ~irq_w1c) | {evt_tx_done, evt_rx_pkt};
            if (do_write && (wr_word == ADDR_W'(OFF_IRQ_MASK)) && wr_strb[0]) irq_mask <= wr_data[1:0];
            irq <= |(irq_stat & irq_mask);
        end
    end
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        case (rd_word)
            ADDR_W'(OFF_CTRL):   rd_data = {30'd0, cfg.rx_en, cfg.tx_en};
            ADDR_W'(OFF_MAC_LO): rd_data = cfg.mac[31:0];
            ADDR_W'(OFF_MAC_HI): rd_data = {16'h0000, cfg.mac[47:32]};
            ADDR_W'(OFF_SRC_IP): rd_data = cfg.src_ip;
            ADDR_W'(OFF_DST_IP): rd_data = cfg.dst_ip;
            ADDR_W'(OFF_PORTS):  rd_data = {cfg.src_port, cfg.dst_port};
            ADDR_W'(OFF_STATUS): rd_data = {30'd0, sts_tx_busy, sts_link_up};
            ADDR_W'(OFF_TX_CNT): rd_data = tx_cnt;
            ADDR_W'(OFF_RX_CNT): rd_data = rx_cnt;
`ifdef UDP_REGS_IRQ_EN
            ADDR_W'(OFF_IRQ_STAT): rd_data = {30'd0, irq_stat};
            ADDR_W'(OFF_IRQ_MASK): rd_data = {30'd0, irq_mask};
`endif
            default: rd_err = 1'b1;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            S_AXI_rvalid <= 1'b0;
            S_AXI_rdata  <= '0;
            S_AXI_rresp  <= RESP_OKAY;
        end else if (ar_hs) begin
            S_AXI_rvalid <= 1'b1;
            S_AXI_rdata  <= rd_data;
            S_AXI_rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
        end else if (S_AXI_rvalid && S_AXI_rready) begin
            S_AXI_rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_udp_axil_regs.sv
// Directed self-checking bench for udp_axil_regs (default build and UDP_REGS_IRQ_EN build).
module tb_udp_axil_regs;

    import udp_regs_pkg::*;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [7:0]  S_AXI_awaddr = '0;
    logic        S_AXI_awvalid = 1'b0;
    logic        S_AXI_awready;
    logic [31:0] S_AXI_wdata = '0;
    logic [3:0]  S_AXI_wstrb = '0;
    logic        S_AXI_wvalid = 1'b0;
    logic        S_AXI_wready;
    logic [1:0]  S_AXI_bresp;
    logic        S_AXI_bvalid;
    logic        S_AXI_bready = 1'b0;
    logic [7:0]  S_AXI_araddr = '0;
    logic        S_AXI_arvalid = 1'b0;
    logic        S_AXI_arready;
    logic [31:0] S_AXI_rdata;
    logic [1:0]  S_AXI_rresp;
    logic        S_AXI_rvalid;
    logic        S_AXI_rready = 1'b0;
    logic [47:0] cfg_mac;
    logic [31:0] cfg_src_ip, cfg_dst_ip;
    logic [15:0] cfg_src_port, cfg_dst_port;
    logic        cfg_tx_en, cfg_rx_en, cfg_soft_rst;
    logic        sts_link_up = 1'b0, sts_tx_busy = 1'b0;
    logic        evt_tx_done = 1'b0, evt_rx_pkt = 1'b0;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    always #5 ACLK = ~ACLK;

    udp_axil_regs #(.ADDR_W(8)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_awaddr(S_AXI_awaddr), .S_AXI_awvalid(S_AXI_awvalid), .S_AXI_awready(S_AXI_awready),
        .S_AXI_wdata(S_AXI_wdata), .S_AXI_wstrb(S_AXI_wstrb), .S_AXI_wvalid(S_AXI_wvalid),
        .S_AXI_wready(S_AXI_wready),
        .S_AXI_bresp(S_AXI_bresp), .S_AXI_bvalid(S_AXI_bvalid), .S_AXI_bready(S_AXI_bready),
        .S_AXI_araddr(S_AXI_araddr), .S_AXI_arvalid(S_AXI_arvalid), .S_AXI_arready(S_AXI_arready),
        .S_AXI_rdata(S_AXI_rdata), .S_AXI_rresp(S_AXI_rresp), .S_AXI_rvalid(S_AXI_rvalid),
        .S_AXI_rready(S_AXI_rready),
        .cfg_mac(cfg_mac), .cfg_src_ip(cfg_src_ip), .cfg_dst_ip(cfg_dst_ip),
        .cfg_src_port(cfg_src_port), .cfg_dst_port(cfg_dst_port),
        .cfg_tx_en(cfg_tx_en), .cfg_rx_en(cfg_rx_en), .cfg_soft_rst(cfg_soft_rst),
        .sts_link_up(sts_link_up), .sts_tx_busy(sts_tx_busy),
        .evt_tx_done(evt_tx_done), .evt_rx_pkt(evt_rx_pkt), .irq(irq)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Callers enter and leave on a falling edge.
    task automatic axi_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
        bit done;
        done = 1'b0;
        S_AXI_araddr  = addr;
        S_AXI_arvalid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            if (S_AXI_arready) done = 1'b1;
            @(negedge ACLK);
        end
        S_AXI_arvalid = 1'b0;
        if (!done) check("ar_timeout", 0, 1);
        check("rvalid_lat", S_AXI_rvalid, 1);
        data = S_AXI_rdata;
        resp = S_AXI_rresp;
        S_AXI_rready = 1'b1;
        @(negedge ACLK);
        S_AXI_rready = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] addr, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp);
        logic [31:0] d;
        logic [1:0]  r;
        axi_read(addr, d, r);
        check({tag, "_data"}, d, exp_data);
        check({tag, "_resp"}, r, exp_resp);
    endtask

    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp);
        bit aw_done, w_done, a, w;
        aw_done = 1'b0;
        w_done  = 1'b0;
        S_AXI_awaddr  = addr;
        S_AXI_awvalid = 1'b1;
        S_AXI_wdata   = data;
        S_AXI_wstrb   = strb;
        S_AXI_wvalid  = 1'b1;
        for (int i = 0; i < 20 && !(aw_done && w_done); i++) begin
            a = S_AXI_awvalid && S_AXI_awready;
            w = S_AXI_wvalid && S_AXI_wready;
            @(negedge ACLK);
            if (a) begin S_AXI_awvalid = 1'b0; aw_done = 1'b1; end
            if (w) begin S_AXI_wvalid  = 1'b0; w_done  = 1'b1; end
        end
        S_AXI_awvalid = 1'b0;
        S_AXI_wvalid  = 1'b0;
        if (!(aw_done && w_done)) check("aw_w_timeout", 0, 1);
        check("bvalid_lat", S_AXI_bvalid, 1);
        resp = S_AXI_bresp;
        S_AXI_bready = 1'b1;
        @(negedge ACLK);
        S_AXI_bready = 1'b0;
    endtask

    task automatic wr_chk(input string tag, input logic [7:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [1:0] exp_resp);
        logic [1:0] r;
        axi_write(addr, data, strb, r);
        check({tag, "_bresp"}, r, exp_resp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge ACLK);
        check("rst_awready", S_AXI_awready, 1);
        check("rst_wready", S_AXI_wready, 1);
        check("rst_arready", S_AXI_arready, 1);
        check("rst_bvalid", S_AXI_bvalid, 0);
        check("rst_rvalid", S_AXI_rvalid, 0);
        check("rst_rdata", S_AXI_rdata, 0);
        check("rst_irq", irq, 0);
        check("rst_mac", cfg_mac, 48'h0200_0000_0001);
        check("rst_ports", {cfg_src_port, cfg_dst_port}, {16'd5000, 16'd5001});
        check("rst_en", {cfg_tx_en, cfg_rx_en, cfg_soft_rst}, 3'b000);
        ARESET = 1'b0;
        @(negedge ACLK);

        rd_chk("src_ip_def", 8'h0C, 32'hC0A8_010A, RESP_OKAY);
        rd_chk("mac_lo_def", 8'h04, 32'h0000_0001, RESP_OKAY);
        rd_chk("mac_hi_def", 8'h08, 32'h0000_0200, RESP_OKAY);

        // W leads AW by three cycles
        S_AXI_wdata  = 32'h1388_1389;
        S_AXI_wstrb  = 4'hF;
        S_AXI_wvalid = 1'b1;
        @(negedge ACLK);
        S_AXI_wvalid = 1'b0;
        check("w_first_wready", S_AXI_wready, 0);
        repeat (2) begin
            check("w_first_nobvalid", S_AXI_bvalid, 0);
            @(negedge ACLK);
        end
        S_AXI_awaddr  = 8'h14;
        S_AXI_awvalid = 1'b1;
        @(negedge ACLK);
        S_AXI_awvalid = 1'b0;
        check("w_first_bvalid", S_AXI_bvalid, 1);
        check("w_first_bresp", S_AXI_bresp, RESP_OKAY);
        S_AXI_bready = 1'b1;
        @(negedge ACLK);
        S_AXI_bready = 1'b0;
        check("w_first_ready_back", {S_AXI_awready, S_AXI_wready}, 2'b11);
        check("ports_cfg", {cfg_src_port, cfg_dst_port}, 32'h1388_1389);

        wr_chk("dst_ip_strb", 8'h10, 32'hAABB_CCDD, 4'b0010, RESP_OKAY);
        rd_chk("dst_ip_strb", 8'h10, 32'hC0A8_CC64, RESP_OKAY);
        check("dst_ip_cfg", cfg_dst_ip, 32'hC0A8_CC64);

        // B back-pressure, with a second AW waiting behind it
        S_AXI_awaddr = 8'h0C; S_AXI_awvalid = 1'b1;
        S_AXI_wdata = 32'h0A0B_0C0D; S_AXI_wstrb = 4'hF; S_AXI_wvalid = 1'b1;
        @(negedge ACLK);
        S_AXI_wvalid = 1'b0;
        S_AXI_awaddr = 8'h00;
        for (int i = 0; i < 5; i++) begin
            check("bp_bvalid", S_AXI_bvalid, 1);
            check("bp_bresp", S_AXI_bresp, RESP_OKAY);
            check("bp_readies", {S_AXI_awready, S_AXI_wready}, 2'b00);
            @(negedge ACLK);
        end
        S_AXI_bready = 1'b1;
        @(negedge ACLK);
        S_AXI_bready = 1'b0;
        check("bp_aw_reopen", S_AXI_awready, 1);
        @(negedge ACLK);
        S_AXI_awvalid = 1'b0;
        check("bp_aw2_taken", S_AXI_awready, 0);
        check("bp_aw2_nob", S_AXI_bvalid, 0);
        S_AXI_wdata = 32'h0000_0003; S_AXI_wvalid = 1'b1;
        @(negedge ACLK);
        S_AXI_wvalid = 1'b0;
        check("bp_w2_bvalid", S_AXI_bvalid, 1);
        S_AXI_bready = 1'b1;
        @(negedge ACLK);
        S_AXI_bready = 1'b0;
        check("bp_src_ip", cfg_src_ip, 32'h0A0B_0C0D);
        check("bp_ctrl_cfg", {cfg_tx_en, cfg_rx_en}, 2'b11);
        rd_chk("ctrl_rd", 8'h00, 32'h0000_0003, RESP_OKAY);

        // counters
        evt_tx_done = 1'b1;
        repeat (3) @(negedge ACLK);
        evt_tx_done = 1'b0;
        S_AXI_araddr = 8'h1C; S_AXI_arvalid = 1'b1; evt_tx_done = 1'b1;
        @(negedge ACLK);
        S_AXI_arvalid = 1'b0; evt_tx_done = 1'b0;
        check("cnt_coinc_rvalid", S_AXI_rvalid, 1);
        check("cnt_coinc_pre", S_AXI_rdata, 32'd3);
        S_AXI_rready = 1'b1;
        @(negedge ACLK);
        S_AXI_rready = 1'b0;
        rd_chk("tx_cnt_post", 8'h1C, 32'd4, RESP_OKAY);

        force dut.u_tx_cnt.count = 32'hFFFF_FFFF;
        #1;
        release dut.u_tx_cnt.count;
        @(negedge ACLK);
        rd_chk("tx_cnt_max", 8'h1C, 32'hFFFF_FFFF, RESP_OKAY);
        evt_tx_done = 1'b1;
        @(negedge ACLK);
        evt_tx_done = 1'b0;
        rd_chk("tx_cnt_wrap", 8'h1C, 32'd0, RESP_OKAY);

        evt_rx_pkt = 1'b1;
        repeat (2) @(negedge ACLK);
        evt_rx_pkt = 1'b0;
        rd_chk("rx_cnt", 8'h20, 32'd2, RESP_OKAY);

        // soft reset pulse; tx event both with the write and with the clear cycle
        S_AXI_awaddr = 8'h00; S_AXI_awvalid = 1'b1;
        S_AXI_wdata = 32'h0000_0004; S_AXI_wstrb = 4'hF; S_AXI_wvalid = 1'b1;
        evt_tx_done = 1'b1;
        @(negedge ACLK);
        S_AXI_awvalid = 1'b0; S_AXI_wvalid = 1'b0;
        check("srst_bvalid", S_AXI_bvalid, 1);
        check("srst_pulse_hi", cfg_soft_rst, 1);
        S_AXI_bready = 1'b1;
        @(negedge ACLK);
        S_AXI_bready = 1'b0; evt_tx_done = 1'b0;
        check("srst_pulse_lo", cfg_soft_rst, 0);
        check("srst_en_cleared", {cfg_tx_en, cfg_rx_en}, 2'b00);
        check("srst_cfg_kept", {cfg_src_port, cfg_dst_port}, 32'h1388_1389);
        rd_chk("srst_tx_cnt", 8'h1C, 32'd0, RESP_OKAY);
        rd_chk("srst_rx_cnt", 8'h20, 32'd0, RESP_OKAY);
        rd_chk("srst_ctrl", 8'h00, 32'd0, RESP_OKAY);

        sts_link_up = 1'b1;
        rd_chk("status_link", 8'h18, 32'd1, RESP_OKAY);
        sts_tx_busy = 1'b1;
        rd_chk("status_both", 8'h18, 32'd3, RESP_OKAY);

        wr_chk("ro_write", 8'h1C, 32'hDEAD_BEEF, 4'hF, RESP_OKAY);
        rd_chk("ro_unchanged", 8'h1C, 32'd0, RESP_OKAY);

        wr_chk("mac_lo_wr", 8'h04, 32'h1234_5678, 4'hF, RESP_OKAY);
        wr_chk("mac_hi_wr", 8'h08, 32'hFFFF_ABCD, 4'b0011, RESP_OKAY);
        check("mac_cfg", cfg_mac, 48'hABCD_1234_5678);
        rd_chk("mac_hi_rd", 8'h08, 32'h0000_ABCD, RESP_OKAY);

        rd_chk("unmapped_rd", 8'h3C, 32'd0, RESP_SLVERR);
        wr_chk("unmapped_wr", 8'h3C, 32'h5555_5555, 4'hF, RESP_SLVERR);
        check("unmapped_mac", cfg_mac, 48'hABCD_1234_5678);
        check("unmapped_ip", {cfg_src_ip, cfg_dst_ip}, {32'h0A0B_0C0D, 32'hC0A8_CC64});

`ifdef UDP_REGS_IRQ_EN
        wr_chk("irq_mask_wr", 8'h28, 32'd1, 4'hF, RESP_OKAY);
        check("irq_idle", irq, 0);
        evt_rx_pkt = 1'b1;
        @(negedge ACLK);
        evt_rx_pkt = 1'b0;
        check("irq_reg_delay", irq, 0);
        @(negedge ACLK);
        check("irq_set", irq, 1);
        rd_chk("irq_stat_rd", 8'h24, 32'd1, RESP_OKAY);
        wr_chk("irq_w1c", 8'h24, 32'd1, 4'hF, RESP_OKAY);
        check("irq_cleared", irq, 0);
        rd_chk("irq_stat_clr", 8'h24, 32'd0, RESP_OKAY);
`else
        rd_chk("irq_stat_unmapped", 8'h24, 32'd0, RESP_SLVERR);
        wr_chk("irq_mask_unmapped", 8'h28, 32'd1, 4'hF, RESP_SLVERR);
        evt_rx_pkt = 1'b1;
        @(negedge ACLK);
        evt_rx_pkt = 1'b0;
        repeat (2) @(negedge ACLK);
        check("irq_tied_low", irq, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
